dram_cmd_scheduler: RTL and testbench
=====================================

// Module: dram_cmd_scheduler
// PURPOSE
//  Sits between the decoded L2 request stream and the DRAM command interface.
//  Turns each accepted read/write into the minimal PRE/ACT/RW command sequence using a per-bank open-row table.
//  Inserts periodic refresh from an internal interval timer.
//  Drives every command over a 4-phase cmd_req/cmd_ack handshake.
// PARAMETERS
//  NUM_OF_BANKS      8    banks; BW = $clog2(NUM_OF_BANKS)
//  NUM_OF_ROWS       128  rows per bank; RW_ = $clog2(NUM_OF_ROWS)
//  NUM_OF_COLS       8    cols per row; CW = $clog2(NUM_OF_COLS)
//  REFRESH_INTERVAL  780  clk cycles between refresh requests (>=16)
// PORTS
//  clk           in   1    single clock, rising edge
//  rst           in   1    synchronous, active-high reset
//  req_valid     in   1    decoded L2 request present
//  req_ready     out  1    scheduler accepts request this cycle
//  req_rw        in   1    1=write, 0=read
//  req_bank      in   BW   bank id
//  req_row       in   RW_  row id
//  req_col       in   CW   column id
//  cmd_req       out  1    command request (4-phase)
//  cmd_ack       in   1    command acknowledge from DRAM side
//  cmd           out  2    00=REF 01=ACT 10=RW 11=PRE
//  cmd_bank      out  BW   target bank of cmd
//  cmd_row       out  RW_  target row (ACT)
//  cmd_col       out  CW   target column (RW)
//  cmd_rw        out  1    1=write, 0=read (valid with cmd=RW)
//  refresh_flag  out  1    high while in REFRESH state
//  busy          out  1    high in any state but IDLE
// BEHAVIOUR
//  Reset values (sync, rst=1): all outputs 0; open-row valid bits cleared; refresh timer loaded with REFRESH_INTERVAL-1; refresh_pending=0; state=IDLE.
//  Reset mid-handshake: cmd_req drops the cycle after rst; the in-flight command is abandoned.
//  FSM states: IDLE, PRE, ACT, RW, REF. Each non-IDLE state has two phases:
//   - REQ: cmd_req=1, cmd fields stable, until cmd_ack=1.
//   - REL: cmd_req=0, until cmd_ack=0. On exit, advance state.
//  IDLE:
//   - req_ready = !refresh_pending && !rst.
//   - refresh_pending has priority: go to REF.
//   - Otherwise, on req_valid&&req_ready, capture req_* and route:
//     - bank open, same row (hit): RW.
//     - bank open, other row (conflict): PRE -> ACT -> RW.
//     - bank closed: ACT -> RW.
//   - First cmd_req is asserted on the cycle after acceptance (latency 1).
//  Sequencing and table updates:
//   - PRE done: clear open[bank].
//   - ACT done: set open[bank], row[bank]=captured row.
//   - RW done: return to IDLE (open row is kept).
//   - REF done: clear all open bits, clear refresh_pending, return to IDLE.
//  Refresh timing:
//   - Refresh is never inserted mid-sequence; a pending refresh waits for IDLE.
//   - Timer decrements every cycle. At 0 it sets refresh_pending and reloads. A second expiry while already pending is absorbed.
//  Handshake rules:
//   - cmd_* outputs are held constant from cmd_req rise until the REL phase completes.
//   - An ack that is already high in IDLE is ignored; REQ is not entered until cmd_ack=0.
//  Simultaneous events: if timer expiry and acceptance fall on the same cycle, the request wins. Refresh follows that request's sequence.
//  Widths: bank/row/col are carried unmodified. No arithmetic beyond the timer decrement.
// STRUCTURE
//  dram_ctrl_pkg: cmd encoding localparams (CMD_REF/ACT/RW/PRE), FSM state encoding, phase encoding.
//  Sub-module dram_refresh_timer:
//   - ports: clk, rst, clear_pending, refresh_pending.
//   - contains the down-counter and pending flag.
//  Open-row table: NUM_OF_BANKS x (1 valid + RW_ row) regs, local to the scheduler.
// TESTING
//  Bench drives cmd_ack 1 cycle after each cmd_req edge. Expected sequences:
//  1 Reset, then write bank3/row5/col2 -> ACT(b3,r5), RW(c2,w=1); open[3]=1, busy returns to 0.
//  2 Read b3/r5/c7 after test 1 -> single RW(b3,c7,rw=0); no ACT/PRE (row hit).
//  3 Write b3/r9/c0 after test 2 -> PRE(b3), ACT(b3,r9), RW(c0); row[3]=9.
//  4 Idle for REFRESH_INTERVAL cycles -> req_ready=0, REF issued, refresh_flag=1 during it. Next access to b3 issues ACT first.
//  5 Timer expiry on the accept cycle of b1/r2 -> full ACT/RW for b1 completes first, then REF.
//  6 Assert rst while cmd_req=1 in ACT -> cmd_req=0 next cycle, all open bits 0, timer reloaded, state IDLE.

Source files
------------

// File: rtl/dram_ctrl_pkg.sv
// Shared encodings for the DRAM command scheduler: command codes, FSM states,
// handshake phases and the fixed PRE -> ACT -> RW -> IDLE successor order.
package dram_ctrl_pkg;

    localparam logic [1:0] CMD_REF = 2'b00;
    localparam logic [1:0] CMD_ACT = 2'b01;
    localparam logic [1:0] CMD_RW  = 2'b10;
    localparam logic [1:0] CMD_PRE = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PRE  = 3'd1,
        ST_ACT  = 3'd2,
        ST_RW   = 3'd3,
        ST_REF  = 3'd4
    } state_t;

    typedef enum logic {
        PH_REQ = 1'b0,
        PH_REL = 1'b1
    } phase_t;

    function automatic logic [1:0] state_cmd(input state_t st);
        logic [1:0] c;
        case (st)
            ST_PRE:  c = CMD_PRE;
            ST_ACT:  c = CMD_ACT;
            ST_RW:   c = CMD_RW;
            default: c = CMD_REF;
        endcase
        return c;
    endfunction

    function automatic state_t state_succ(input state_t st);
        state_t n;
        case (st)
            ST_PRE:  n = ST_ACT;
            ST_ACT:  n = ST_RW;
            default: n = ST_IDLE;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/dram_refresh_timer.sv
// Free-running refresh interval down-counter with a sticky pending flag that
// the scheduler clears once the refresh command has completed.
module dram_refresh_timer #(
    parameter int REFRESH_INTERVAL = 780
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_pending,
    output logic refresh_pending
);

    localparam int TW = $clog2(REFRESH_INTERVAL);
    localparam logic [TW-1:0] RELOAD  = TW'(REFRESH_INTERVAL - 1);
    localparam logic [TW-1:0] CNT_ONE = {{(TW-1){1'b0}}, 1'b1};
    localparam logic [TW-1:0] CNT_ZERO = {TW{1'b0}};

    logic [TW-1:0] count_r;
    logic          pending_r;
    logic          expire_s;

    assign expire_s = (count_r == CNT_ZERO);

    // Interval counter and pending flag; a fresh expiry outranks a same-cycle clear
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r   <= RELOAD;
            pending_r <= 1'b0;
        end else begin
            count_r <= expire_s ? RELOAD : (count_r - CNT_ONE);
            if (expire_s) begin
                pending_r <= 1'b1;
            end else if (clear_pending) begin
                pending_r <= 1'b0;
            end else begin
                pending_r <= pending_r;
            end
        end
    end

    assign refresh_pending = pending_r;

endmodule

// File: rtl/dram_cmd_scheduler.sv
// Converts accepted L2 read/write requests into PRE/ACT/RW sequences using a
// per-bank open-row table, inserts refreshes between sequences, 4-phase cmd handshake.
module dram_cmd_scheduler
    import dram_ctrl_pkg::*;
#(
    parameter int NUM_OF_BANKS     = 8,
    parameter int NUM_OF_ROWS      = 128,
    parameter int NUM_OF_COLS      = 8,
    parameter int REFRESH_INTERVAL = 780,
    localparam int BW  = $clog2(NUM_OF_BANKS),
    localparam int RW_ = $clog2(NUM_OF_ROWS),
    localparam int CW  = $clog2(NUM_OF_COLS)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           req_valid,
    output logic           req_ready,
    input  logic           req_rw,
    input  logic [BW-1:0]  req_bank,
    input  logic [RW_-1:0] req_row,
    input  logic [CW-1:0]  req_col,
    output logic           cmd_req,
    input  logic           cmd_ack,
    output logic [1:0]     cmd,
    output logic [BW-1:0]  cmd_bank,
    output logic [RW_-1:0] cmd_row,
    output logic [CW-1:0]  cmd_col,
    output logic           cmd_rw,
    output logic           refresh_flag,
    output logic           busy
);

    state_t         state_r, state_s;
    phase_t         phase_r, phase_s;
    logic           cmd_req_r, cmd_req_s;
    logic [1:0]     cmd_r;
    logic [BW-1:0]  cmd_bank_r;
    logic [RW_-1:0] cmd_row_r;
    logic [CW-1:0]  cmd_col_r;
    logic           cmd_rw_r;
    logic           busy_r;
    logic           refresh_flag_r;
    logic           open_r     [NUM_OF_BANKS];
    logic [RW_-1:0] open_row_r [NUM_OF_BANKS];
    logic           accept_s;
    logic           done_s;
    logic           req_ready_s;
    logic           refresh_pending_s;
    logic           clear_pending_s;

    dram_refresh_timer #(
        .REFRESH_INTERVAL(REFRESH_INTERVAL)
    ) u_refresh_timer (
        .clk            (clk),
        .rst            (rst),
        .clear_pending  (clear_pending_s),
        .refresh_pending(refresh_pending_s)
    );

    assign req_ready_s     = (state_r == ST_IDLE) && !refresh_pending_s && !rst;
    assign clear_pending_s = done_s && (state_r == ST_REF);

    // Next-state logic; cmd_req only rises while cmd_ack is low, so a stale ack is ignored
    always_comb begin
        state_s   = state_r;
        phase_s   = phase_r;
        cmd_req_s = cmd_req_r;
        accept_s  = 1'b0;
        done_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                phase_s = PH_REQ;
                if (refresh_pending_s) begin
                    state_s   = ST_REF;
                    cmd_req_s = !cmd_ack;
                end else if (req_valid && req_ready_s) begin
                    accept_s  = 1'b1;
                    cmd_req_s = !cmd_ack;
                    if (!open_r[req_bank]) begin
                        state_s = ST_ACT;
                    end else if (open_row_r[req_bank] == req_row) begin
                        state_s = ST_RW;
                    end else begin
                        state_s = ST_PRE;
                    end
                end else begin
                    cmd_req_s = 1'b0;
                end
            end
            ST_PRE, ST_ACT, ST_RW, ST_REF: begin
                if (phase_r == PH_REQ) begin
                    if (!cmd_req_r) begin
                        cmd_req_s = !cmd_ack;
                    end else if (cmd_ack) begin
                        cmd_req_s = 1'b0;
                        phase_s   = PH_REL;
                    end else begin
                        cmd_req_s = 1'b1;
                    end
                end else begin
                    if (!cmd_ack) begin
                        done_s    = 1'b1;
                        phase_s   = PH_REQ;
                        state_s   = state_succ(state_r);
                        cmd_req_s = (state_s != ST_IDLE);
                    end else begin
                        cmd_req_s = 1'b0;
                    end
                end
            end
            default: begin
                state_s   = ST_IDLE;
                phase_s   = PH_REQ;
                cmd_req_s = 1'b0;
            end
        endcase
    end

    // FSM state and registered status/command outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r        <= ST_IDLE;
            phase_r        <= PH_REQ;
            cmd_req_r      <= 1'b0;
            cmd_r          <= 2'b00;
            busy_r         <= 1'b0;
            refresh_flag_r <= 1'b0;
        end else begin
            state_r        <= state_s;
            phase_r        <= phase_s;
            cmd_req_r      <= cmd_req_s;
            cmd_r          <= (state_s != ST_IDLE) ? state_cmd(state_s) : cmd_r;
            busy_r         <= (state_s != ST_IDLE);
            refresh_flag_r <= (state_s == ST_REF);
        end
    end

    // Captured request fields double as the held cmd_* address outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_bank_r <= {BW{1'b0}};
            cmd_row_r  <= {RW_{1'b0}};
            cmd_col_r  <= {CW{1'b0}};
            cmd_rw_r   <= 1'b0;
        end else if (accept_s) begin
            cmd_bank_r <= req_bank;
            cmd_row_r  <= req_row;
            cmd_col_r  <= req_col;
            cmd_rw_r   <= req_rw;
        end else begin
            cmd_bank_r <= cmd_bank_r;
            cmd_row_r  <= cmd_row_r;
            cmd_col_r  <= cmd_col_r;
            cmd_rw_r   <= cmd_rw_r;
        end
    end

    // Open-row table, updated only when a PRE, ACT or REF handshake completes
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_OF_BANKS; i++) begin
                open_r[i]     <= 1'b0;
                open_row_r[i] <= {RW_{1'b0}};
            end
        end else if (done_s) begin
            case (state_r)
                ST_PRE: open_r[cmd_bank_r] <= 1'b0;
                ST_ACT: begin
                    open_r[cmd_bank_r]     <= 1'b1;
                    open_row_r[cmd_bank_r] <= cmd_row_r;
                end
                ST_REF: begin
                    for (int i = 0; i < NUM_OF_BANKS; i++) begin
                        open_r[i] <= 1'b0;
                    end
                end
                default: ;
            endcase
        end else begin
            for (int i = 0; i < NUM_OF_BANKS; i++) begin
                open_r[i]     <= open_r[i];
                open_row_r[i] <= open_row_r[i];
            end
        end
    end

    assign req_ready    = req_ready_s;
    assign cmd_req      = cmd_req_r;
    assign cmd          = cmd_r;
    assign cmd_bank     = cmd_bank_r;
    assign cmd_row      = cmd_row_r;
    assign cmd_col      = cmd_col_r;
    assign cmd_rw       = cmd_rw_r;
    assign busy         = busy_r;
    assign refresh_flag = refresh_flag_r;

endmodule

// File: tb/tb_dram_cmd_scheduler.sv
// Bench for dram_cmd_scheduler: transaction-level reference model checked every
// cycle, scripted directed scenarios with literal expectations, then random traffic.
module tb_dram_cmd_scheduler;
    import dram_ctrl_pkg::*;

    localparam int NB = 8, NR = 128, NC = 8, RI = 780;
    localparam int BW = 3, RWW = 7, CW = 3;

    logic clk = 1'b0, rst = 1'b1;
    logic req_valid = 1'b0, req_rw = 1'b0, cmd_ack = 1'b0;
    logic [BW-1:0] req_bank = '0;
    logic [RWW-1:0] req_row = '0;
    logic [CW-1:0] req_col = '0;
    logic req_ready, cmd_req, cmd_rw, refresh_flag, busy;
    logic [1:0] cmd;
    logic [BW-1:0] cmd_bank;
    logic [RWW-1:0] cmd_row;
    logic [CW-1:0] cmd_col;

    dram_cmd_scheduler #(.NUM_OF_BANKS(NB), .NUM_OF_ROWS(NR), .NUM_OF_COLS(NC),
                         .REFRESH_INTERVAL(RI)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_rw(req_rw), .req_bank(req_bank), .req_row(req_row), .req_col(req_col),
        .cmd_req(cmd_req), .cmd_ack(cmd_ack), .cmd(cmd), .cmd_bank(cmd_bank),
        .cmd_row(cmd_row), .cmd_col(cmd_col), .cmd_rw(cmd_rw),
        .refresh_flag(refresh_flag), .busy(busy));

    always #5 clk = ~clk;

    typedef struct { logic [1:0] cmd; int bank; int row; int col; logic rw; } cmd_t;

    int n_checks = 0, n_fail = 0;
    bit random_ack = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic cmd_t mk(input logic [1:0] c, input int b, input int r, input int col, input logic w);
        cmd_t t;
        t.cmd = c; t.bank = b; t.row = r; t.col = col; t.rw = w;
        return t;
    endfunction

    // ---------------- reference model (command-level) ----------------
    cmd_t exp_q[$];
    cmd_t obs_log[$];
    cmd_t cur;
    bit cur_active = 1'b0, cur_acked = 1'b0;
    bit m_open[NB];
    int m_row[NB];
    bit m_pending = 1'b0;
    int since_rst = 0;
    bit p_rst = 1'b1, p_valid = 1'b0, p_ack = 1'b0, p_ready_exp = 1'b0, p_cmd_req = 1'b0;
    int p_bank = 0, p_row = 0, p_col = 0;
    bit p_rw = 1'b0;

    always @(negedge clk) begin : compare
        bit ready_exp;
        if (p_rst) begin
            exp_q.delete();
            cur_active = 1'b0; cur_acked = 1'b0; m_pending = 1'b0; since_rst = 0;
            foreach (m_open[i]) m_open[i] = 1'b0;
            check("rst_cmd", int'(cmd), 0);
            check("rst_cmd_bank", int'(cmd_bank), 0);
            check("rst_cmd_row", int'(cmd_row), 0);
            check("rst_cmd_col", int'(cmd_col), 0);
            check("rst_cmd_rw", int'(cmd_rw), 0);
        end else begin
            since_rst++;
            if (cur_active) begin
                if (!cur_acked) begin
                    if (p_ack) cur_acked = 1'b1;
                end else if (!p_ack) begin
                    if (cur.cmd == CMD_PRE) m_open[cur.bank] = 1'b0;
                    if (cur.cmd == CMD_ACT) begin m_open[cur.bank] = 1'b1; m_row[cur.bank] = cur.row; end
                    if (cur.cmd == CMD_REF) begin
                        foreach (m_open[i]) m_open[i] = 1'b0;
                        m_pending = 1'b0;
                    end
                    cur_active = 1'b0;
                    if (exp_q.size() > 0) begin
                        cur = exp_q.pop_front(); cur_active = 1'b1; cur_acked = 1'b0;
                    end
                end
            end else if (m_pending) begin
                cur = mk(CMD_REF, 0, 0, 0, 1'b0); cur_active = 1'b1; cur_acked = 1'b0;
            end else if (p_valid && p_ready_exp) begin
                if (!m_open[p_bank]) begin
                    exp_q.push_back(mk(CMD_ACT, p_bank, p_row, p_col, p_rw));
                end else if (m_row[p_bank] != p_row) begin
                    exp_q.push_back(mk(CMD_PRE, p_bank, p_row, p_col, p_rw));
                    exp_q.push_back(mk(CMD_ACT, p_bank, p_row, p_col, p_rw));
                end
                exp_q.push_back(mk(CMD_RW, p_bank, p_row, p_col, p_rw));
                cur = exp_q.pop_front(); cur_active = 1'b1; cur_acked = 1'b0;
            end
            if (since_rst % RI == 0) m_pending = 1'b1;
        end

        ready_exp = !cur_active && !m_pending && !rst;
        check("cmd_req", int'(cmd_req), int'(cur_active && !cur_acked));
        check("busy", int'(busy), int'(cur_active));
        check("refresh_flag", int'(refresh_flag), int'(cur_active && cur.cmd == CMD_REF));
        check("req_ready", int'(req_ready), int'(ready_exp));
        if (cur_active) begin
            check("cmd", int'(cmd), int'(cur.cmd));
            if (cur.cmd != CMD_REF) check("cmd_bank", int'(cmd_bank), cur.bank);
            if (cur.cmd == CMD_ACT) check("cmd_row", int'(cmd_row), cur.row);
            if (cur.cmd == CMD_RW) begin
                check("cmd_col", int'(cmd_col), cur.col);
                check("cmd_rw", int'(cmd_rw), int'(cur.rw));
            end
        end
        if (cmd_req && !p_cmd_req)
            obs_log.push_back(mk(cmd, int'(cmd_bank), int'(cmd_row), int'(cmd_col), cmd_rw));

        p_rst = rst; p_valid = req_valid; p_ack = cmd_ack; p_ready_exp = ready_exp;
        p_cmd_req = cmd_req;
        p_bank = int'(req_bank); p_row = int'(req_row); p_col = int'(req_col); p_rw = req_rw;
    end

    // ---------------- DRAM-side acknowledger ----------------
    initial begin : responder
        int dly = 0;
        forever begin
            @(posedge clk); #1;
            if (cmd_ack != cmd_req) begin
                if (dly == 0) begin
                    cmd_ack = cmd_req;
                    dly = random_ack ? int'($urandom_range(0, 2)) : 0;
                end else begin
                    dly--;
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic do_req(input int b, input int r, input int c, input bit w);
        int n = 0;
        bit ok = 1'b0;
        req_bank = BW'(b); req_row = RWW'(r); req_col = CW'(c); req_rw = w; req_valid = 1'b1;
        while (!ok && n < 3000) begin
            ok = req_ready;
            @(posedge clk); #1;
            n++;
        end
        req_valid = 1'b0;
        if (!ok) check("req_accept_timeout", 0, 1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy || cmd_req || cmd_ack) && n < 3000) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 3000) check("idle_timeout", 0, 1);
        @(posedge clk); #1;
    endtask

    task automatic wait_log(input int target);
        int n = 0;
        while (obs_log.size() < target && n < 3000) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 3000) check("log_timeout", obs_log.size(), target);
    endtask

    task automatic check_log(input string name, input int idx, input int c, input int b,
                             input int r, input int col, input int w);
        if (idx >= obs_log.size()) begin
            check({name, "_missing"}, obs_log.size(), idx + 1);
        end else begin
            check({name, "_cmd"}, int'(obs_log[idx].cmd), c);
            if (b >= 0) check({name, "_bank"}, obs_log[idx].bank, b);
            if (r >= 0) check({name, "_row"}, obs_log[idx].row, r);
            if (col >= 0) check({name, "_col"}, obs_log[idx].col, col);
            if (w >= 0) check({name, "_rw"}, int'(obs_log[idx].rw), w);
        end
    endtask

    // ---------------- scenario sequence ----------------
    initial begin : stimulus
        int base;
        int n;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;

        // 1: closed bank -> ACT, RW
        base = obs_log.size();
        do_req(3, 5, 2, 1'b1); wait_idle();
        check("t1_count", obs_log.size() - base, 2);
        check_log("t1_act", base, CMD_ACT, 3, 5, -1, -1);
        check_log("t1_rw", base + 1, CMD_RW, 3, -1, 2, 1);
        check("t1_busy", int'(busy), 0);

        // 2: row hit -> RW only
        base = obs_log.size();
        do_req(3, 5, 7, 1'b0); wait_idle();
        check("t2_count", obs_log.size() - base, 1);
        check_log("t2_rw", base, CMD_RW, 3, -1, 7, 0);

        // 3: row conflict -> PRE, ACT, RW
        base = obs_log.size();
        do_req(3, 9, 0, 1'b1); wait_idle();
        check("t3_count", obs_log.size() - base, 3);
        check_log("t3_pre", base, CMD_PRE, 3, -1, -1, -1);
        check_log("t3_act", base + 1, CMD_ACT, 3, 9, -1, -1);
        check_log("t3_rw", base + 2, CMD_RW, 3, -1, 0, 1);

        // 4: idle until refresh, then b3 must be re-activated
        base = obs_log.size();
        n = 0;
        while (!(cmd_req && cmd == CMD_REF) && n < RI + 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("t4_ref_seen", int'(cmd_req && cmd == CMD_REF), 1);
        check("t4_ref_flag", int'(refresh_flag), 1);
        check("t4_ready_low", int'(req_ready), 0);
        wait_idle();
        base = obs_log.size();
        do_req(3, 9, 1, 1'b0); wait_idle();
        check_log("t4_act", base, CMD_ACT, 3, 9, -1, -1);
        check_log("t4_rw", base + 1, CMD_RW, 3, -1, 1, 0);

        // 5: accept b1/r2 on the very cycle the timer expires
        n = 0;
        while ((since_rst % RI) != RI - 2 && n < 2 * RI) begin
            @(posedge clk); #1;
            n++;
        end
        base = obs_log.size();
        do_req(1, 2, 0, 1'b1);
        wait_log(base + 3);
        wait_idle();
        check_log("t5_act", base, CMD_ACT, 1, 2, -1, -1);
        check_log("t5_rw", base + 1, CMD_RW, 1, -1, 0, 1);
        check_log("t5_ref", base + 2, CMD_REF, -1, -1, -1, -1);

        // 6: reset in the middle of an ACT handshake
        do_req(6, 1, 0, 1'b0);
        check("t6_in_act_req", int'(cmd_req), 1);
        check("t6_in_act_cmd", int'(cmd), int'(CMD_ACT));
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("t6_req_dropped", int'(cmd_req), 0);
        check("t6_busy", int'(busy), 0);
        repeat (5) @(posedge clk);
        #1;
        base = obs_log.size();
        do_req(3, 9, 4, 1'b1); wait_idle();
        check_log("t6_act_after_rst", base, CMD_ACT, 3, 9, -1, -1);
        check_log("t6_rw_after_rst", base + 1, CMD_RW, 3, -1, 4, 1);

        // random traffic with variable ack latency
        random_ack = 1'b1;
        for (int i = 0; i < 200; i++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            do_req(int'($urandom_range(0, NB - 1)), int'($urandom_range(0, 3)),
                   int'($urandom_range(0, NC - 1)), 1'($urandom_range(0, 1)));
        end
        wait_idle();
        repeat (20) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
